// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Loader phases, in the order a well-formed frame walks through them.
  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // Frame header is a 16-bit little-endian word count.
  localparam int HDR_BYTES      = 2;
  // Instructions are 32 bits, assembled least-significant byte first.
  localparam int BYTES_PER_WORD = 4;

  // Byte address of instruction word 'idx' relative to 'base', in 64-bit arithmetic.
  function automatic logic [63:0] word_byte_addr(input logic [63:0] base,
                                                 input logic [15:0] idx);
    return base + {46'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes into little-endian 32-bit words and pulses word_valid
// for one cycle after the edge that accepted the last byte of a word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        clear,      // drop any partial word and restart at byte 0
  input  logic        push,       // byte_in is consumed on this edge
  input  logic [7:0]  byte_in,
  output logic        last_byte,  // the next pushed byte completes a word
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;

  // Shift bytes in from the top so the first byte ends up in bits [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    word_d  = word_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (push) begin
      if (cnt_q == LAST_IDX) begin
        word_d  = {byte_in, shift_q};
        valid_d = 1'b1;
        cnt_d   = 2'd0;
      end else begin
        shift_d = {byte_in, shift_q[23:8]};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  // Assembly registers; the completed word is held until the next one replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      valid_q <= 1'b0;
      word_q  <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign last_byte  = (cnt_q == LAST_IDX);
  assign word_valid = valid_q;
  assign word_data  = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (count, payload, XOR check), writes
// each 32-bit instruction to consecutive word addresses and holds the core in
// reset until a complete image with a matching checksum is in memory.
//
// Stream handshake: a byte moves on a rising clock edge exactly when in_valid
// and in_ready are both high; in_valid with in_ready low leaves the byte with
// the sender, and in_ready depends only on the current state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [7:0]  count_lo_q, count_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [63:0] addr_q, addr_d;

  logic        xfer;
  logic [15:0] hdr_count;
  logic        asm_clear;
  logic        asm_push;
  logic        asm_last;
  logic        asm_word_valid;
  logic [31:0] asm_word_data;

  assign xfer      = in_valid && in_ready;
  assign hdr_count = {in_data, count_lo_q};

  // Frame parser: next state plus checksum, word index and address updates.
  always_comb begin
    state_d    = state_q;
    count_lo_d = count_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    asm_clear  = 1'b0;
    asm_push   = 1'b0;
    unique case (state_q)
      ST_HDR_LO: begin
        if (xfer) begin
          count_lo_d = in_data;
          state_d    = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          // Empty images and images larger than the memory are rejected outright.
          if (hdr_count == 16'd0 || {16'd0, hdr_count} > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            count_d    = hdr_count;
            word_idx_d = 16'd0;
            chk_d      = 8'd0;
            asm_clear  = 1'b1;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_push = 1'b1;
          chk_d    = chk_q ^ in_data;
          if (asm_last) begin
            // Address is registered alongside the assembled word so both
            // are valid in the single imem_we cycle.
            addr_d     = word_byte_addr(BASE_ADDR, word_idx_q);
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE: begin
        if (reload) begin
          state_d = ST_HDR_LO;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_HDR_LO;
      end
    endcase
  end

  // Parser state and bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HDR_LO;
      count_lo_q <= 8'd0;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      chk_q      <= 8'd0;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q    <= state_d;
      count_lo_q <= count_lo_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
    end
  end

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .push       (asm_push),
    .byte_in    (in_data),
    .last_byte  (asm_last),
    .word_valid (asm_word_valid),
    .word_data  (asm_word_data)
  );

  // Only the loading phases take bytes; the core runs only from a verified image.
  assign in_ready     = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign cpu_reset    = (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERROR);
  assign imem_we      = asm_word_valid;
  assign imem_wdata   = asm_word_data;
  assign imem_addr    = addr_q;
  // The word index doubles as the count of words written in this load.
  assign words_loaded = word_idx_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames driven through the byte stream, a
// frame-position model predicting every output each cycle, and literal checks
// for the hand-computed images.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          MAX_WORDS = 256;
  localparam logic [63:0] BASE_ADDR = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Tracks position within the current frame; status 0 = loading, 1 = done, 2 = rejected.
  int          m_status = 0;
  int          m_pos = 0;
  int          m_n = 0;
  int          m_words = 0;
  logic [7:0]  m_lo = 8'h00;
  logic [7:0]  m_xor = 8'h00;
  logic [31:0] m_word = 32'h0;
  logic        m_we = 1'b0;
  logic [95:0] exp_q[$];
  logic [95:0] cap_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_status = 0;
      m_pos    = 0;
      m_words  = 0;
      m_we     = 1'b0;
      exp_q.delete();
    end else begin
      m_we = 1'b0;
      if (m_status == 0 && in_valid) begin
        if (m_pos == 0) begin
          m_lo = in_data;
        end else if (m_pos == 1) begin
          m_n = int'({in_data, m_lo});
          if (m_n == 0 || m_n > MAX_WORDS) begin
            m_status = 2;
          end else begin
            m_words = 0;
            m_xor   = 8'h00;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          int k;
          k = m_pos - 2;
          m_xor = m_xor ^ in_data;
          m_word[8 * (k % 4) +: 8] = in_data;
          if (k % 4 == 3) begin
            exp_q.push_back({BASE_ADDR + 64'(4 * (k / 4)), m_word});
            m_words++;
            m_we = 1'b1;
          end
        end else begin
          m_status = (in_data == m_xor) ? 1 : 2;
        end
        m_pos++;
      end else if (m_status == 1 && reload) begin
        m_status = 0;
        m_pos    = 0;
      end
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    logic [95:0] e;
    check("in_ready",     96'(in_ready),     96'(m_status == 0));
    check("cpu_reset",    96'(cpu_reset),    96'(m_status != 1));
    check("done",         96'(done),         96'(m_status == 1));
    check("error",        96'(error),        96'(m_status == 2));
    check("words_loaded", 96'(words_loaded), 96'(m_words));
    check("imem_we",      96'(imem_we),      96'(m_we));
    if (m_we) begin
      e = exp_q.pop_front();
      if (imem_we === 1'b1) check("imem_write", {imem_addr, imem_wdata}, e);
    end
    if (imem_we === 1'b1) cap_q.push_back({imem_addr, imem_wdata});
  end

  // ---------------- drivers ----------------
  logic [7:0] frame[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   gap;
    logic rdy;
    bit   ok;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      idle(1);
    end
    in_valid = 1'b1;
    in_data  = b;
    ok       = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) send_byte(frame[i], max_gap);
  endtask

  task automatic start_frame(input logic [15:0] n);
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) frame.push_back(w[8 * i +: 8]);
  endtask

  task automatic end_frame();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < frame.size(); i++) x = x ^ frame[i];
    frame.push_back(x);
  endtask

  task automatic hold_valid(input int n, input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    idle(n);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values.
    idle(2);
    check("rst_in_ready",     96'(in_ready),     96'(1));
    check("rst_imem_we",      96'(imem_we),      96'(0));
    check("rst_imem_addr",    96'(imem_addr),    96'(BASE_ADDR));
    check("rst_imem_wdata",   96'(imem_wdata),   96'(0));
    check("rst_cpu_reset",    96'(cpu_reset),    96'(1));
    check("rst_done",         96'(done),         96'(0));
    check("rst_error",        96'(error),        96'(0));
    check("rst_words_loaded", 96'(words_loaded), 96'(0));
    check("rst_dbg_state",    96'(dbg_state),    96'(ST_HDR_LO));
    reset = 1'b1;
    idle(1);

    // Two-instruction image streamed back to back; check byte = XOR of payload = 0x70.
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
    cap_q.delete();
    send_range(0, 10, 0);
    check("a_done",         96'(done),         96'(1));
    check("a_cpu_reset",    96'(cpu_reset),    96'(0));
    check("a_words_loaded", 96'(words_loaded), 96'(2));
    check("a_write_count",  96'(cap_q.size()), 96'(2));
    if (cap_q.size() == 2) begin
      check("a_word0", cap_q[0], {64'h0, 32'h00500013});
      check("a_word1", cap_q[1], {64'h4, 32'h00A00093});
    end

    // Bytes offered in DONE are not consumed.
    hold_valid(3, 8'h5A);
    check("done_hold", 96'(done), 96'(1));

    // Reload then the same image with a corrupted check byte.
    pulse_reload();
    check("reload_cpu_reset", 96'(cpu_reset), 96'(1));
    check("reload_in_ready",  96'(in_ready),  96'(1));
    frame[10] = 8'h71;
    cap_q.delete();
    send_range(0, 10, 0);
    idle(1);
    check("bad_error",       96'(error),        96'(1));
    check("bad_cpu_reset",   96'(cpu_reset),    96'(1));
    check("bad_in_ready",    96'(in_ready),     96'(0));
    check("bad_write_count", 96'(cap_q.size()), 96'(2));
    hold_valid(2, 8'h00);
    pulse_reload();
    check("bad_sticky", 96'(error), 96'(1));

    // Zero-length header.
    apply_reset();
    cap_q.delete();
    frame = '{8'h00, 8'h00};
    send_range(0, 1, 0);
    idle(3);
    check("n0_error",  96'(error),        96'(1));
    check("n0_writes", 96'(cap_q.size()), 96'(0));

    // Header one word larger than the memory.
    apply_reset();
    frame = '{8'h01, 8'h01};
    send_range(0, 1, 0);
    idle(3);
    check("nmax1_error",  96'(error),        96'(1));
    check("nmax1_writes", 96'(cap_q.size()), 96'(0));

    // Header exactly at capacity is accepted.
    apply_reset();
    frame = '{8'h00, 8'h01};
    send_range(0, 1, 0);
    idle(1);
    check("nmax_no_error", 96'(error),    96'(0));
    check("nmax_ready",    96'(in_ready), 96'(1));

    // Three words with random gaps and a stray reload mid-payload.
    apply_reset();
    start_frame(16'd3);
    add_word(32'h11223344);
    add_word(32'hCAFEF00D);
    add_word(32'h0BADC0DE);
    end_frame();
    cap_q.delete();
    send_range(0, 7, 3);
    pulse_reload();
    send_range(8, 14, 3);
    check("gap_done",        96'(done),         96'(1));
    check("gap_write_count", 96'(cap_q.size()), 96'(3));
    if (cap_q.size() == 3) check("gap_word1", cap_q[1], {64'h4, 32'hCAFEF00D});

    // Reset after five payload bytes, then a complete image.
    apply_reset();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
    send_range(0, 6, 0);
    idle(1);
    check("mid_words_before", 96'(words_loaded), 96'(1));
    reset = 1'b0;
    idle(1);
    check("mid_rst_words", 96'(words_loaded), 96'(0));
    check("mid_rst_wdata", 96'(imem_wdata),   96'(0));
    check("mid_rst_addr",  96'(imem_addr),    96'(BASE_ADDR));
    check("mid_rst_ready", 96'(in_ready),     96'(1));
    reset = 1'b1;
    idle(1);
    cap_q.delete();
    send_range(0, 10, 0);
    check("mid_done",  96'(done),         96'(1));
    check("mid_words", 96'(words_loaded), 96'(2));
    if (cap_q.size() > 0) check("mid_word0", cap_q[0], {64'h0, 32'h00500013});

    // Reload from DONE and load a single word (check = EF^BE^AD^DE = 0x22).
    pulse_reload();
    check("rl_cpu_reset", 96'(cpu_reset), 96'(1));
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    cap_q.delete();
    send_range(0, 6, 0);
    check("rl_done",        96'(done),         96'(1));
    check("rl_words",       96'(words_loaded), 96'(1));
    check("rl_write_count", 96'(cap_q.size()), 96'(1));
    if (cap_q.size() == 1) check("rl_word0", cap_q[0], {64'h0, 32'hDEADBEEF});

    idle(3);
    check("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the pipelined core's instruction memory from a byte stream. It accepts a framed image over a valid/ready byte interface and assembles little-endian 32-bit instructions. It writes them to consecutive word addresses and holds the core in reset until a complete, checksum-verified image is in place. It is the write side of the instruction-fetch path: the core only reads instruction memory, and this block fills it.

## Interface
Parameters:
- MAX_WORDS, 256, instruction-memory capacity in 32-bit words; larger images are rejected.
- BASE_ADDR, 64'h0, byte address of the first instruction written.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to restart loading; honoured only in DONE.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  64  byte address of the word being written, word-aligned.
- imem_wdata  output  32  assembled instruction.
- cpu_reset  output  1  active-high reset to the core; high until a valid image is loaded.
- done  output  1  image loaded and verified.
- error  output  1  frame rejected; sticky until reset.
- words_loaded  output  16  count of words written in the current load.

## Operation
- Frame format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then 4N payload bytes, then one CHECK byte.
- Payload word i is bytes 4i..4i+3 of the payload, least-significant byte first. It is written to BASE_ADDR + 4i.
- CHECK must equal the XOR of all 4N payload bytes. Header bytes are excluded from the checksum.
- A byte transfers on a rising edge with in_valid && in_ready.

FSM states and transitions:
- HDR_LO: on transfer, latch the low count byte and go to HDR_HI.
- HDR_HI: on transfer, latch the high count byte. If N == 0 or N > MAX_WORDS, go to ERROR; otherwise clear the word index, byte index, checksum and words_loaded, then go to DATA.
- DATA: on each transfer, shift the byte into the assembly register and XOR it into the checksum. On the 4th byte of a word, issue the write and increment the word index. After word N-1 is written, go to CHECK.
- CHECK: on transfer, go to DONE if the byte matches the checksum; otherwise go to ERROR.
- DONE: if reload is seen, go to HDR_LO and raise cpu_reset again.
- ERROR: terminal until reset.

Output behaviour:
- in_ready = 1 in HDR_LO, HDR_HI, DATA and CHECK; 0 in DONE and ERROR.
- cpu_reset = 1 in every state except DONE.
- done = 1 only in DONE. error = 1 only in ERROR.

Boundary conditions:
- in_valid while in_ready is low: the byte is ignored and not consumed.
- reload outside DONE: ignored.
- reset asserted mid-frame: the partial image is abandoned, all outputs return to reset values, and loading restarts at HDR_LO.
- On a checksum mismatch the memory contents are already modified. The core is nevertheless kept in reset.

## Timing
Reset values:
- in_ready 1 (state HDR_LO).
- imem_we 0, imem_addr BASE_ADDR, imem_wdata 0.
- cpu_reset 1, done 0, error 0, words_loaded 0.

Cycle-level behaviour:
- imem_we, imem_addr and imem_wdata are registered. imem_we is high for exactly one cycle, the cycle after the edge that accepted the 4th byte of a word. Address and data are stable during that cycle.
- words_loaded increments on the same edge that raises imem_we.
- With in_valid held high, the loader accepts one byte per cycle. Minimum frame time is 4N+3 cycles, and DONE is entered on the edge accepting CHECK.
- cpu_reset falls on the edge entering DONE. The final imem write completes at least one cycle before the CHECK byte is accepted, so the core never fetches an unwritten word.
- imem_addr is computed as BASE_ADDR + {word_index, 2'b00} in 64-bit arithmetic. For N ≤ MAX_WORDS, word_index never wraps.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enumeration (HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR);
  - localparams for header length (2) and bytes per word (4).
- One sub-module, word_assembler: shifts in bytes, counts 0..3, and emits a one-cycle word_valid with the 32-bit word. The FSM, checksum, counters and address generation stay in imem_loader.

## Test plan
- N=2, payload 13 00 50 00 93 00 A0 00, CHECK = XOR → writes 32'h00500013 @0x0 and 32'h00A00093 @0x4. done=1, cpu_reset falls on the CHECK edge, words_loaded=2.
- Same frame with a corrupted CHECK byte → both writes occur, then error=1, cpu_reset stays 1, in_ready=0.
- Header N=0, and separately N=MAX_WORDS+1 → ERROR after HDR_HI, with no imem_we pulse.
- in_valid toggled randomly in DATA → written words unchanged, exactly one imem_we per 4 accepted bytes.
- reset asserted after 5 payload bytes, then a full valid frame → outputs return to reset values; the new image loads from BASE_ADDR and words_loaded restarts at 0.
- In DONE, pulse reload, then send an N=1 frame → cpu_reset rises the next cycle, one word is written at BASE_ADDR, and done is reasserted.
